// File: rtl/pipeline_seq_pkg.sv
// Shared types for the capture/process pipeline sequencer.
package pipeline_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } seq_state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles since the last clear and flags the final allowed cycle.
module stage_watchdog
  import pipeline_seq_pkg::*;
#(
  parameter int unsigned TO_W           = 20,
  parameter int unsigned TIMEOUT_CYCLES = 1048575
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam bit              WD_ON    = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] LAST_CNT = WD_ON ? TO_W'(TIMEOUT_CYCLES - 1) : '0;

  logic [TO_W-1:0] cnt;
  logic [TO_W-1:0] cnt_n;

  always_comb begin
    cnt_n = cnt;
    if (clr) begin
      cnt_n = '0;
    end else if (en) begin
      cnt_n = cnt + TO_W'(1);
    end
  end

  // expire mirrors "current count is the last allowed cycle", so it lines up with the FSM state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      expire <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      expire <= WD_ON && (cnt_n == LAST_CNT);
    end
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Top-level sequencer: walks the stages in order via enable/done handshakes,
// drives the shared RWM port, counts frames and reports per-stage timeouts.
module pipeline_sequencer
  import pipeline_seq_pkg::*;
#(
  parameter int unsigned            NUM_STAGES     = 3,
  parameter logic [NUM_STAGES-1:0]  STAGE_MEM_MASK = NUM_STAGES'(3'b011),
  parameter logic [NUM_STAGES-1:0]  STAGE_RW_MASK  = NUM_STAGES'(3'b001),
  parameter int unsigned            TIMEOUT_CYCLES = 1048575,
  parameter int unsigned            TO_W           = 20,
  parameter int unsigned            FRAME_CNT_W    = 16,
  localparam int unsigned           STAGE_W        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   continuous,
  input  logic                   abort,
  input  logic [NUM_STAGES-1:0]  stage_done,
  output logic [NUM_STAGES-1:0]  stage_enable,
  output logic                   mem_enable,
  output logic                   mem_rw,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   timeout_err,
  output logic [STAGE_W-1:0]     err_stage,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [STAGE_W-1:0] LAST_IDX = STAGE_W'(NUM_STAGES - 1);

  seq_state_e             state, state_n;
  logic [STAGE_W-1:0]     idx, idx_n, err_stage_n;
  logic                   cont_q, cont_n;
  logic [FRAME_CNT_W-1:0] frame_count_n;
  logic [NUM_STAGES-1:0]  stage_enable_n;
  logic                   mem_enable_n, mem_rw_n;
  logic                   wd_clr, wd_en, wd_expire;

  stage_watchdog #(
    .TO_W           (TO_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Next state; abort beats done, done beats timeout
  always_comb begin
    state_n       = state;
    idx_n         = idx;
    cont_n        = cont_q;
    err_stage_n   = err_stage;
    frame_count_n = frame_count;
    wd_clr        = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          idx_n   = '0;
          cont_n  = continuous;
          wd_clr  = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (stage_done[idx]) begin
          if (idx == LAST_IDX) begin
            state_n       = DONE;
            frame_count_n = frame_count + FRAME_CNT_W'(1);
          end else begin
            idx_n  = idx + STAGE_W'(1);
            wd_clr = 1'b1;
          end
        end else if (wd_expire) begin
          state_n     = ERROR;
          err_stage_n = idx;
        end
      end
      DONE: begin
        if (cont_q && !abort) begin
          state_n = RUN;
          idx_n   = '0;
          wd_clr  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      ERROR: begin
        if (abort) begin
          state_n = IDLE;
        end else if (start) begin
          state_n = RUN;
          idx_n   = '0;
          cont_n  = continuous;
          wd_clr  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    wd_en          = (state_n == RUN);
    stage_enable_n = (state_n == RUN) ? (NUM_STAGES'(1) << idx_n) : '0;
    mem_enable_n   = (state_n == RUN) && STAGE_MEM_MASK[idx_n];
    mem_rw_n       = (mem_enable_n && STAGE_RW_MASK[idx_n]) ? RW_READ : RW_WRITE;
  end

  // Outputs are registered from next-state values so they line up with the state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      cont_q       <= 1'b0;
      stage_enable <= '0;
      mem_enable   <= 1'b0;
      mem_rw       <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
      err_stage    <= '0;
      frame_count  <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      cont_q       <= cont_n;
      stage_enable <= stage_enable_n;
      mem_enable   <= mem_enable_n;
      mem_rw       <= mem_rw_n;
      busy         <= (state_n == RUN) || (state_n == DONE);
      frame_done   <= (state_n == DONE);
      timeout_err  <= (state_n == ERROR);
      err_stage    <= err_stage_n;
      frame_count  <= frame_count_n;
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Bench for pipeline_sequencer: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_sequencer;

  localparam int       NS       = 3;
  localparam int       TMO      = 16;
  localparam logic [2:0] MEM_MASK = 3'b011;
  localparam logic [2:0] RW_MASK  = 3'b001;
  localparam int       P_IDLE = 0, P_RUN = 1, P_DONE = 2, P_ERR = 3;

  logic       clk, rst_n, start, continuous, abort;
  logic [2:0] stage_done, stage_enable;
  logic       mem_enable, mem_rw, busy, frame_done, timeout_err;
  logic [1:0] err_stage, frame_count;

  int n_checks = 0;
  int n_err    = 0;

  pipeline_sequencer #(
    .NUM_STAGES     (NS),
    .STAGE_MEM_MASK (MEM_MASK),
    .STAGE_RW_MASK  (RW_MASK),
    .TIMEOUT_CYCLES (TMO),
    .TO_W           (5),
    .FRAME_CNT_W    (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .continuous   (continuous),
    .abort        (abort),
    .stage_done   (stage_done),
    .stage_enable (stage_enable),
    .mem_enable   (mem_enable),
    .mem_rw       (mem_rw),
    .busy         (busy),
    .frame_done   (frame_done),
    .timeout_err  (timeout_err),
    .err_stage    (err_stage),
    .frame_count  (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase, active stage, cycles spent in that stage, frames completed
  int ph = P_IDLE, stg = 0, age = 0, frames = 0, err_stg = 0;
  bit loop_mode = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = P_IDLE; stg = 0; age = 0; frames = 0; loop_mode = 1'b0;
    end else begin
      case (ph)
        P_IDLE: if (start) begin ph = P_RUN; stg = 0; age = 0; loop_mode = continuous; end
        P_RUN: begin
          if (abort) ph = P_IDLE;
          else if (stage_done[stg]) begin
            if (stg == NS - 1) begin ph = P_DONE; frames++; end
            else begin stg++; age = 0; end
          end else if (age == TMO - 1) begin ph = P_ERR; err_stg = stg; end
          else age++;
        end
        P_DONE: if (loop_mode && !abort) begin ph = P_RUN; stg = 0; age = 0; end
                else ph = P_IDLE;
        default: begin
          if (abort) ph = P_IDLE;
          else if (start) begin ph = P_RUN; stg = 0; age = 0; loop_mode = continuous; end
        end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model
  initial begin : compare
    logic [2:0] e_en;
    logic       e_mem;
    forever begin
      @(posedge clk);
      #1;
      e_en  = (ph == P_RUN) ? 3'(1 << stg) : 3'b000;
      e_mem = (ph == P_RUN) && MEM_MASK[stg];
      chk("m_stage_enable", 32'(stage_enable), 32'(e_en));
      chk("m_mem_enable",   32'(mem_enable),   32'(e_mem));
      chk("m_mem_rw",       32'(mem_rw),       32'(e_mem && RW_MASK[stg]));
      chk("m_busy",         32'(busy),         32'(ph == P_RUN || ph == P_DONE));
      chk("m_frame_done",   32'(frame_done),   32'(ph == P_DONE));
      chk("m_timeout_err",  32'(timeout_err),  32'(ph == P_ERR));
      chk("m_frame_count",  32'(frame_count),  32'(frames % 4));
      if (ph == P_ERR) chk("m_err_stage", 32'(err_stage), 32'(err_stg));
    end
  end

  task automatic cyc(input logic s, input logic c, input logic a, input logic [2:0] d);
    @(negedge clk);
    start = s; continuous = c; abort = a; stage_done = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'b000);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; stage_done = 3'b000;
    @(posedge clk);
    #2;
    chk("rst_enable", 32'(stage_enable), 32'd0);
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_count",  32'(frame_count),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int exp_wrap[5];
    exp_wrap = '{1, 2, 3, 0, 1};
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; abort = 1'b0; stage_done = 3'b000;
    do_reset();

    // Single-shot frame
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t1_en0", 32'(stage_enable), 32'h1);
    chk("t1_mem0", 32'({mem_enable, mem_rw}), 32'h3);
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 3'b001);
    chk("t1_en1", 32'(stage_enable), 32'h2);
    chk("t1_mem1", 32'({mem_enable, mem_rw}), 32'h2);
    idle(6);
    cyc(1'b0, 1'b0, 1'b0, 3'b010);
    chk("t1_en2", 32'(stage_enable), 32'h4);
    chk("t1_mem2", 32'({mem_enable, mem_rw}), 32'h0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 3'b100);
    chk("t1_fdone", 32'(frame_done), 32'h1);
    chk("t1_count", 32'(frame_count), 32'h1);
    idle(1);
    chk("t1_idle_busy", 32'(busy), 32'h0);
    chk("t1_pulse_end", 32'(frame_done), 32'h0);

    // Continuous mode, abort during stage 1 of the fourth frame
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 3'b000);
    for (int f = 0; f < 3; f++) begin
      for (int s = 0; s < NS; s++) begin
        idle(2);
        cyc(1'b0, 1'b0, 1'b0, 3'(1 << s));
      end
      chk("t2_frame_count", 32'(frame_count), 32'(f + 1));
    end
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 3'b001);
    idle(1);
    cyc(1'b0, 1'b1, 1'b1, 3'b000);
    chk("t2_abort_en", 32'(stage_enable), 32'h0);
    chk("t2_abort_fd", 32'(frame_done), 32'h0);
    chk("t2_abort_cnt", 32'(frame_count), 32'h3);

    // Synchronous reset mid-frame, during stage 1
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    cyc(1'b0, 1'b0, 1'b0, 3'b001);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; stage_done = 3'b000;
    #3;
    chk("t5_pre_edge_en", 32'(stage_enable), 32'h2);
    chk("t5_pre_edge_cnt", 32'(frame_count), 32'h3);
    @(posedge clk);
    #2;
    chk("t5_post_en", 32'(stage_enable), 32'h0);
    chk("t5_post_cnt", 32'(frame_count), 32'h0);
    chk("t5_post_mem", 32'({mem_enable, mem_rw, busy}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Watchdog timeout in stage 1, then restart from ERROR
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    cyc(1'b0, 1'b0, 1'b0, 3'b001);
    idle(15);
    chk("t3_last_ok_en", 32'(stage_enable), 32'h2);
    chk("t3_last_ok_err", 32'(timeout_err), 32'h0);
    idle(1);
    chk("t3_err", 32'(timeout_err), 32'h1);
    chk("t3_err_stage", 32'(err_stage), 32'h1);
    chk("t3_err_en", 32'(stage_enable), 32'h0);
    cyc(1'b1, 1'b0, 1'b0, 3'b000);
    chk("t3_restart_en", 32'(stage_enable), 32'h1);
    chk("t3_restart_err", 32'(timeout_err), 32'h0);

    // Done on the expiring cycle, stray done, abort colliding with final done
    idle(4);
    cyc(1'b0, 1'b0, 1'b0, 3'b100);
    idle(10);
    cyc(1'b0, 1'b0, 1'b0, 3'b001);
    chk("t4_expire_adv", 32'(stage_enable), 32'h2);
    chk("t4_expire_noerr", 32'(timeout_err), 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 3'b010);
    cyc(1'b0, 1'b0, 1'b1, 3'b100);
    chk("t4_abort_fd", 32'(frame_done), 32'h0);
    chk("t4_abort_busy", 32'(busy), 32'h0);
    chk("t4_abort_cnt", 32'(frame_count), 32'h0);

    // Frame counter wrap at 2 bits
    do_reset();
    cyc(1'b1, 1'b1, 1'b0, 3'b000);
    for (int f = 0; f < 5; f++) begin
      cyc(1'b0, 1'b0, 1'b0, 3'b001);
      cyc(1'b0, 1'b0, 1'b0, 3'b010);
      cyc(1'b0, 1'b0, 1'b0, 3'b100);
      chk("t6_wrap_count", 32'(frame_count), 32'(exp_wrap[f]));
      idle(1);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b000);

    // Randomized traffic; second half uses sparse dones so timeouts occur
    for (int i = 0; i < 4000; i++) begin
      int den;
      den = (i < 2000) ? 3 : 11;
      @(negedge clk);
      rst_n      = ($urandom_range(0, 599) != 0);
      start      = ($urandom_range(0, 7) == 0);
      continuous = 1'($urandom_range(0, 1));
      abort      = ($urandom_range(0, 39) == 0);
      stage_done = {($urandom_range(0, den) == 0), ($urandom_range(0, den) == 0),
                    ($urandom_range(0, den) == 0)};
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; stage_done = 3'b000;
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
